// File: rtl/atctlc2axi500_sync_multi.sv
// Multi-channel level synchronizer: per-channel sync chain, optional stability filter, edge pulses.
// Optional sticky event flags are enabled by defining ATCTLC2AXI500_SYNC_STICKY_EN.
module atctlc2axi500_sync_multi #(
  parameter int              CH          = 4,
  parameter int              SYNC_STAGE  = 2,
  parameter logic [CH-1:0]   RESET_VALUE = {CH{1'b0}},
  parameter int              FILT_CYC    = 0
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic [CH-1:0] d,
  output logic [CH-1:0] q,
  output logic [CH-1:0] q_rise,
  output logic [CH-1:0] q_fall,
  input  logic [CH-1:0] evt_clr,
  output logic [CH-1:0] evt_sticky
);

  localparam int CNT_W = (FILT_CYC < 1) ? 1 : $clog2(FILT_CYC + 1);

  if (SYNC_STAGE < 2) begin : g_bad_stage
    $error("atctlc2axi500_sync_multi: SYNC_STAGE must be at least 2");
  end

`ifndef ATCTLC2AXI500_SYNC_STICKY_EN
  logic w_unused_clr;
  assign w_unused_clr = ^evt_clr;
`endif

  for (genvar i = 0; i < CH; i++) begin : g_ch
    logic [SYNC_STAGE-1:0] r_sync;
    logic                  w_raw;
    logic                  w_q;
    logic                  r_qd;
    logic                  w_rise;
    logic                  w_fall;

    always_ff @(posedge clk) begin
      if (!resetn) begin
        r_sync <= {SYNC_STAGE{RESET_VALUE[i]}};
      end else begin
        r_sync <= {r_sync[SYNC_STAGE-2:0], d[i]};
      end
    end

    assign w_raw = r_sync[SYNC_STAGE-1];

    if (FILT_CYC == 0) begin : g_nofilt
      assign w_q = w_raw;
    end else begin : g_filt
      localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_CYC - 1);
      logic [CNT_W-1:0] r_cnt;
      logic             r_q;

      // Any return of raw to the held level restarts the count, so only a
      // change that persists FILT_CYC consecutive cycles is accepted.
      always_ff @(posedge clk) begin
        if (!resetn) begin
          r_cnt <= '0;
          r_q   <= RESET_VALUE[i];
        end else if (w_raw == r_q) begin
          r_cnt <= '0;
        end else if (r_cnt == CNT_LAST) begin
          r_cnt <= '0;
          r_q   <= w_raw;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end

      assign w_q = r_q;
    end

    always_ff @(posedge clk) begin
      if (!resetn) begin
        r_qd <= RESET_VALUE[i];
      end else begin
        r_qd <= w_q;
      end
    end

    assign w_rise    = w_q & ~r_qd;
    assign w_fall    = ~w_q & r_qd;
    assign q[i]      = w_q;
    assign q_rise[i] = w_rise;
    assign q_fall[i] = w_fall;

`ifdef ATCTLC2AXI500_SYNC_STICKY_EN
    logic r_sticky;

    // A new edge outranks a clear arriving in the same cycle.
    always_ff @(posedge clk) begin
      if (!resetn) begin
        r_sticky <= 1'b0;
      end else if (w_rise | w_fall) begin
        r_sticky <= 1'b1;
      end else if (evt_clr[i]) begin
        r_sticky <= 1'b0;
      end
    end

    assign evt_sticky[i] = r_sticky;
`else
    assign evt_sticky[i] = 1'b0;
`endif
  end

endmodule

// File: tb/tb_atctlc2axi500_sync_multi.sv
// Directed bench for atctlc2axi500_sync_multi: four instances cover default sync,
// a 3-stage chain, a 4-cycle filter and an all-ones reset value.
module tb_atctlc2axi500_sync_multi;

`ifdef ATCTLC2AXI500_SYNC_STICKY_EN
  localparam bit STICKY_ON = 1'b1;
`else
  localparam bit STICKY_ON = 1'b0;
`endif

  logic       clk;
  logic       resetn0, resetn1, resetn2, resetn3;
  logic [3:0] dIn0, dIn1, dIn2, dIn3;
  logic [3:0] evtClr0, evtClr1, evtClr2, evtClr3;
  logic [3:0] q0, q1, q2, q3;
  logic [3:0] qRise0, qRise1, qRise2, qRise3;
  logic [3:0] qFall0, qFall1, qFall2, qFall3;
  logic [3:0] evtSticky0, evtSticky1, evtSticky2, evtSticky3;

  int checks;
  int failures;

  atctlc2axi500_sync_multi #(.CH(4), .SYNC_STAGE(2), .RESET_VALUE(4'b0000), .FILT_CYC(0)) u0 (
    .clk(clk), .resetn(resetn0), .d(dIn0), .q(q0), .q_rise(qRise0), .q_fall(qFall0),
    .evt_clr(evtClr0), .evt_sticky(evtSticky0));

  atctlc2axi500_sync_multi #(.CH(4), .SYNC_STAGE(3), .RESET_VALUE(4'b0000), .FILT_CYC(0)) u1 (
    .clk(clk), .resetn(resetn1), .d(dIn1), .q(q1), .q_rise(qRise1), .q_fall(qFall1),
    .evt_clr(evtClr1), .evt_sticky(evtSticky1));

  atctlc2axi500_sync_multi #(.CH(4), .SYNC_STAGE(2), .RESET_VALUE(4'b0000), .FILT_CYC(4)) u2 (
    .clk(clk), .resetn(resetn2), .d(dIn2), .q(q2), .q_rise(qRise2), .q_fall(qFall2),
    .evt_clr(evtClr2), .evt_sticky(evtSticky2));

  atctlc2axi500_sync_multi #(.CH(4), .SYNC_STAGE(2), .RESET_VALUE(4'b1111), .FILT_CYC(0)) u3 (
    .clk(clk), .resetn(resetn3), .d(dIn3), .q(q3), .q_rise(qRise3), .q_fall(qFall3),
    .evt_clr(evtClr3), .evt_sticky(evtSticky3));

  // Free-running clock, 10 time units per period
  always #5 clk = ~clk;

  // Advance n rising edges, then settle 1 unit past the edge before sampling/driving
  task automatic applyStimulus(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [3:0] observed, input logic [3:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
    end
  endtask

  function automatic logic [3:0] stickyExp(input logic [3:0] v);
    return STICKY_ON ? v : 4'b0000;
  endfunction

  // Directed sequence; every expected value is hand-derived from the latency rules
  initial begin
    checks   = 0;
    failures = 0;
    clk      = 1'b0;
    resetn0  = 1'b0; resetn1 = 1'b0; resetn2 = 1'b0; resetn3 = 1'b0;
    dIn0     = 4'b0000; dIn1 = 4'b0000; dIn2 = 4'b0000; dIn3 = 4'b1111;
    evtClr0  = 4'b0000; evtClr1 = 4'b0000; evtClr2 = 4'b0000; evtClr3 = 4'b0000;

    applyStimulus(2);
    resetn1 = 1'b1; resetn2 = 1'b1; resetn3 = 1'b1;

    $display("[TB] default instance: reset hold and release");
    dIn0 = 4'b1010;
    applyStimulus(3);
    checkOutput("u0_rst_q", q0, 4'b0000);
    checkOutput("u0_rst_rise", qRise0, 4'b0000);
    checkOutput("u0_rst_fall", qFall0, 4'b0000);
    checkOutput("u0_rst_sticky", evtSticky0, 4'b0000);

    resetn0 = 1'b1;
    applyStimulus(1);
    checkOutput("u0_rel1_q", q0, 4'b0000);
    checkOutput("u0_rel1_rise", qRise0, 4'b0000);
    applyStimulus(1);
    checkOutput("u0_rel2_q", q0, 4'b1010);
    checkOutput("u0_rel2_rise", qRise0, 4'b1010);
    checkOutput("u0_rel2_fall", qFall0, 4'b0000);
    applyStimulus(1);
    checkOutput("u0_rel3_q", q0, 4'b1010);
    checkOutput("u0_rel3_rise", qRise0, 4'b0000);
    checkOutput("u0_rel3_fall", qFall0, 4'b0000);
    checkOutput("u0_rel3_sticky", evtSticky0, stickyExp(4'b1010));

    $display("[TB] default instance: falling edges");
    dIn0 = 4'b0000;
    applyStimulus(1);
    checkOutput("u0_fall1_q", q0, 4'b1010);
    applyStimulus(1);
    checkOutput("u0_fall2_q", q0, 4'b0000);
    checkOutput("u0_fall2_fall", qFall0, 4'b1010);
    checkOutput("u0_fall2_rise", qRise0, 4'b0000);
    applyStimulus(1);
    checkOutput("u0_fall3_fall", qFall0, 4'b0000);
    checkOutput("u0_fall3_sticky", evtSticky0, stickyExp(4'b1010));

    $display("[TB] default instance: sticky set beats clear");
    evtClr0 = 4'b1111;
    applyStimulus(1);
    checkOutput("u0_clr_sticky", evtSticky0, 4'b0000);
    dIn0 = 4'b1000;
    applyStimulus(2);
    checkOutput("u0_stk_q", q0, 4'b1000);
    checkOutput("u0_stk_rise", qRise0, 4'b1000);
    applyStimulus(1);
    checkOutput("u0_stk_setwins", evtSticky0, stickyExp(4'b1000));
    checkOutput("u0_stk_rise_off", qRise0, 4'b0000);
    applyStimulus(1);
    checkOutput("u0_stk_cleared", evtSticky0, 4'b0000);
    evtClr0 = 4'b0000;

    $display("[TB] default instance: back-to-back toggle");
    dIn0 = 4'b1001;
    applyStimulus(1);
    dIn0 = 4'b1000;
    applyStimulus(1);
    checkOutput("u0_b2b_q1", q0, 4'b1001);
    checkOutput("u0_b2b_rise", qRise0, 4'b0001);
    checkOutput("u0_b2b_fall0", qFall0, 4'b0000);
    applyStimulus(1);
    checkOutput("u0_b2b_q2", q0, 4'b1000);
    checkOutput("u0_b2b_fall", qFall0, 4'b0001);
    checkOutput("u0_b2b_rise0", qRise0, 4'b0000);

    $display("[TB] three-stage instance latency");
    dIn1 = 4'b0001;
    applyStimulus(1);
    checkOutput("u1_e0_q", q1, 4'b0000);
    applyStimulus(1);
    checkOutput("u1_e1_q", q1, 4'b0000);
    applyStimulus(1);
    checkOutput("u1_e2_q", q1, 4'b0001);
    checkOutput("u1_e2_rise", qRise1, 4'b0001);
    applyStimulus(1);
    checkOutput("u1_e3_q", q1, 4'b0001);
    checkOutput("u1_e3_rise", qRise1, 4'b0000);

    $display("[TB] filtered instance: short pulse rejected");
    dIn2 = 4'b0010;
    for (int k = 0; k < 9; k++) begin
      if (k == 3) dIn2 = 4'b0000;
      applyStimulus(1);
      checkOutput("u2_glitch_q", q2, 4'b0000);
      checkOutput("u2_glitch_rise", qRise2, 4'b0000);
    end

    $display("[TB] filtered instance: held change accepted");
    dIn2 = 4'b0010;
    for (int k = 1; k <= 5; k++) begin
      applyStimulus(1);
      checkOutput("u2_rise_wait_q", q2, 4'b0000);
    end
    applyStimulus(1);
    checkOutput("u2_rise_q", q2, 4'b0010);
    checkOutput("u2_rise_pulse", qRise2, 4'b0010);
    applyStimulus(1);
    checkOutput("u2_rise_done", qRise2, 4'b0000);
    checkOutput("u2_rise_hold", q2, 4'b0010);

    dIn2 = 4'b0000;
    for (int k = 1; k <= 5; k++) begin
      applyStimulus(1);
      checkOutput("u2_fall_wait_q", q2, 4'b0010);
    end
    applyStimulus(1);
    checkOutput("u2_fall_q", q2, 4'b0000);
    checkOutput("u2_fall_pulse", qFall2, 4'b0010);
    applyStimulus(1);
    checkOutput("u2_fall_done", qFall2, 4'b0000);

    $display("[TB] all-ones reset instance: mid-stream reset");
    checkOutput("u3_idle_q", q3, 4'b1111);
    dIn3 = 4'b1011;
    applyStimulus(1);
    dIn3 = 4'b1111;
    applyStimulus(1);
    checkOutput("u3_tog_q", q3, 4'b1011);
    checkOutput("u3_tog_fall", qFall3, 4'b0100);
    dIn3    = 4'b1011;
    resetn3 = 1'b0;
    applyStimulus(1);
    checkOutput("u3_rst_q", q3, 4'b1111);
    checkOutput("u3_rst_fall", qFall3, 4'b0000);
    checkOutput("u3_rst_rise", qRise3, 4'b0000);
    resetn3 = 1'b1;
    dIn3    = 4'b1111;
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1);
      checkOutput("u3_rel_q", q3, 4'b1111);
      checkOutput("u3_rel_fall", qFall3, 4'b0000);
      checkOutput("u3_rel_rise", qRise3, 4'b0000);
    end
    checkOutput("u3_sticky", evtSticky3, 4'b0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
